// File: rtl/spi_tx_arbiter_if.sv
// Bus bundle between the SPI transmit requesters, the arbiter and the spi_slave write port.
// master = requesters/spi_slave side, slave = arbiter side.
interface spi_tx_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 24
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      wr_buffer_free;
  logic                      wr_en;
  logic [DATA_W-1:0]         wr_data;
  logic                      grant_valid;
  logic [2:0]                grant_idx;
  logic                      timeout_err;

  modport master (
    output req_valid, req_data, req_last, wr_buffer_free,
    input  req_ready, wr_en, wr_data, grant_valid, grant_idx, timeout_err
  );

  modport slave (
    input  req_valid, req_data, req_last, wr_buffer_free,
    output req_ready, wr_en, wr_data, grant_valid, grant_idx, timeout_err
  );
endinterface

// File: rtl/spi_tx_arbiter.sv
// Round-robin, burst-locking arbiter sharing the spi_slave write path among NUM_REQ requesters.
// Optional stall timeout on a granted burst: define SPI_TX_ARB_TIMEOUT_EN.
module spi_tx_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int DATA_W         = 24,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  spi_tx_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, BURST, HOLD} state_e;

  state_e              state_q;
  logic [2:0]          grant_idx_q;
  logic [2:0]          last_grant_q;
  logic                grant_valid_q;
  logic                wr_en_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic                burst_done_q;

  logic [2:0]          grant_idx_d;
  logic                any_valid;
  int                  rr_dist;
  int                  rr_best;
  logic [NUM_REQ-1:0]  g_onehot;
  logic                g_valid;
  logic                g_last;
  logic [DATA_W-1:0]   g_data;
  logic                accept;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("spi_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  // Round-robin pick: smallest distance above last_grant_q among valid requesters.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    grant_idx_d = '0;
    any_valid   = 1'b0;
    rr_best     = NUM_REQ;
    rr_dist     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rr_dist = i - int'(last_grant_q) - 1;
      if (rr_dist < 0) rr_dist = rr_dist + NUM_REQ;
      if (|(bus.req_valid & (NUM_REQ'(1) << i)) && rr_dist < rr_best) begin
        rr_best     = rr_dist;
        grant_idx_d = 3'(i);
        any_valid   = 1'b1;
      end
    end
  end

  assign g_onehot = NUM_REQ'(1) << grant_idx_q;
  assign g_valid  = |(bus.req_valid & g_onehot);
  assign g_last   = |(bus.req_last & g_onehot);
  assign g_data   = DATA_W'(bus.req_data >> (DATA_W * int'(grant_idx_q)));

  // NOTE: reset_n gates the combinational ready so a requester never sees a word
  // accepted on the edge that is actually resetting the arbiter.
  assign accept        = reset_n && (state_q == BURST) && g_valid && bus.wr_buffer_free;
  assign bus.req_ready = accept ? g_onehot : '0;

  assign bus.wr_en       = wr_en_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.grant_idx   = grant_idx_q;

`ifdef SPI_TX_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] stall_cnt_q;
  logic             timeout_err_q;
  logic             stall;
  logic             stall_expire;

  // Stall only while the granted requester is silent and the slave could take a word.
  assign stall         = (state_q == BURST) && !g_valid && bus.wr_buffer_free;
  assign stall_expire  = stall && (stall_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign bus.timeout_err = timeout_err_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      grant_idx_q   <= '0;
      last_grant_q  <= 3'(NUM_REQ - 1);
      grant_valid_q <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_data_q     <= '0;
      burst_done_q  <= 1'b0;
`ifdef SPI_TX_ARB_TIMEOUT_EN
      stall_cnt_q   <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      wr_en_q <= 1'b0;
`ifdef SPI_TX_ARB_TIMEOUT_EN
      timeout_err_q <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (any_valid) begin
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= 1'b1;
            state_q       <= BURST;
`ifdef SPI_TX_ARB_TIMEOUT_EN
            stall_cnt_q   <= '0;
`endif
          end
        end
        BURST: begin
          if (accept) begin
            wr_en_q      <= 1'b1;
            wr_data_q    <= g_data;
            burst_done_q <= g_last;
            state_q      <= HOLD;
`ifdef SPI_TX_ARB_TIMEOUT_EN
            stall_cnt_q  <= '0;
          end else if (stall_expire) begin
            timeout_err_q <= 1'b1;
            last_grant_q  <= grant_idx_q;
            grant_valid_q <= 1'b0;
            state_q       <= IDLE;
          end else if (stall) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
`endif
          end
        end
        HOLD: begin
          // Covers the spi_slave latency on wr_buffer_free, so it is not looked at here.
          if (burst_done_q) begin
            last_grant_q  <= grant_idx_q;
            grant_valid_q <= 1'b0;
            state_q       <= IDLE;
          end else begin
            state_q <= BURST;
`ifdef SPI_TX_ARB_TIMEOUT_EN
            stall_cnt_q <= '0;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Self-checking bench for spi_tx_arbiter: per-requester source queues feed the bus,
// an expected-word scoreboard is popped on every wr_en.
module tb_spi_tx_arbiter;
  localparam int NUM_REQ = 3;
  localparam int DATA_W  = 24;

  typedef struct {
    int                req;
    logic [DATA_W-1:0] data;
    logic              last;
  } src_t;

  typedef struct {
    logic [2:0]        idx;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic clk;
  logic reset_n;

  spi_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  spi_tx_arbiter #(
    .NUM_REQ       (NUM_REQ),
    .DATA_W        (DATA_W),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  src_t src_q[$];
  exp_t exp_q[$];
  int   wr_cyc_q[$];

  logic [NUM_REQ-1:0]        src_en;
  logic [NUM_REQ-1:0]        acc;
  logic [NUM_REQ-1:0]        drv_v;
  logic [NUM_REQ-1:0]        drv_l;
  logic [NUM_REQ*DATA_W-1:0] drv_d;
  int                        drv_h;
  logic                      prev_wr;
  int                        cyc;
  int                        n_checks;
  int                        n_errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int head_of(input int r);
    for (int k = 0; k < src_q.size(); k++)
      if (src_q[k].req == r) return k;
    return -1;
  endfunction

  task automatic add_word(input int r, input logic [DATA_W-1:0] d, input logic l);
    src_t s;
    s.req = r; s.data = d; s.last = l;
    src_q.push_back(s);
  endtask

  task automatic expect_word(input int r, input logic [DATA_W-1:0] d);
    exp_t e;
    e.idx = 3'(r); e.data = d;
    exp_q.push_back(e);
  endtask

  // Requester model: retire accepted words, present heads at negedge, sample ready before the edge.
  always @(negedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc[i]) begin
        drv_h = head_of(i);
        if (drv_h >= 0) src_q.delete(drv_h);
      end
    end
    drv_v = '0;
    drv_l = '0;
    drv_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      drv_h = head_of(i);
      if (drv_h >= 0 && src_en[i]) begin
        drv_v[i] = 1'b1;
        drv_l[i] = src_q[drv_h].last;
        drv_d[i*DATA_W +: DATA_W] = src_q[drv_h].data;
      end
    end
    bus.req_valid = drv_v;
    bus.req_last  = drv_l;
    bus.req_data  = drv_d;
    #1;
    acc = bus.req_ready;
    if (acc != '0)
      check("ready_onehot", ($onehot(acc) && ((acc & ~drv_v) == '0)) ? 32'd1 : 32'd0, 32'd1);
  end

  // Output monitor: every wr_en pops one expected word.
  always @(negedge clk) begin
    if (bus.wr_en) begin
      if (exp_q.size() == 0) begin
        check("wr_unexpected", {8'd0, bus.wr_data}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("wr_data", {8'd0, bus.wr_data}, {8'd0, e.data});
        check("wr_idx", {29'd0, bus.grant_idx}, {29'd0, e.idx});
      end
      check("wr_not_back_to_back", {31'd0, prev_wr}, 32'd0);
      wr_cyc_q.push_back(cyc);
    end
    prev_wr = bus.wr_en;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic wait_drain(input string tag);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || src_q.size() != 0 || bus.grant_valid) && k < 300) begin
      step();
      k++;
    end
    check(tag, exp_q.size() + src_q.size(), 0);
    exp_q.delete();
    src_q.delete();
  endtask

  task automatic wait_wr(input string tag);
    int k;
    k = 0;
    while (!bus.wr_en && k < 40) begin
      step();
      k++;
    end
    check(tag, {31'd0, bus.wr_en}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"},   {31'd0, bus.wr_en}, 32'd0);
    check({tag, "_wr_data"}, {8'd0, bus.wr_data}, 32'd0);
    check({tag, "_gvalid"},  {31'd0, bus.grant_valid}, 32'd0);
    check({tag, "_gidx"},    {29'd0, bus.grant_idx}, 32'd0);
    check({tag, "_tmo"},     {31'd0, bus.timeout_err}, 32'd0);
    check({tag, "_ready"},   {29'd0, bus.req_ready}, 32'd0);
  endtask

  initial begin
    int bad;
    int k_found;
    n_checks = 0;
    n_errors = 0;
    acc      = '0;
    prev_wr  = 1'b0;
    src_en   = '1;
    reset_n  = 1'b0;
    bus.wr_buffer_free = 1'b1;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;

    step();
    step();
    check_reset_outputs("rst");
    reset_n = 1'b1;

    // Single word latency: ready at n+1, wr_en at n+2, grant drops after HOLD.
    add_word(0, 24'hABCDEF, 1'b1);
    expect_word(0, 24'hABCDEF);
    step();
    check("t1_ready", {29'd0, bus.req_ready}, 32'd1);
    check("t1_gvalid", {31'd0, bus.grant_valid}, 32'd1);
    check("t1_wr_en_early", {31'd0, bus.wr_en}, 32'd0);
    step();
    check("t1_wr_en", {31'd0, bus.wr_en}, 32'd1);
    check("t1_wr_data", {8'd0, bus.wr_data}, 32'hABCDEF);
    check("t1_ready_hold", {29'd0, bus.req_ready}, 32'd0);
    step();
    check("t1_gvalid_drop", {31'd0, bus.grant_valid}, 32'd0);
    check("t1_wr_data_held", {8'd0, bus.wr_data}, 32'hABCDEF);
    wait_drain("t1_drain");

    // Burst lock: req1 4 words uninterrupted, then req2, then req0.
    wr_cyc_q.delete();
    for (int w = 1; w <= 4; w++) add_word(1, 24'(w), (w == 4));
    add_word(0, 24'h0A0A0A, 1'b1);
    add_word(2, 24'h2B2B2B, 1'b1);
    for (int w = 1; w <= 4; w++) expect_word(1, 24'(w));
    expect_word(2, 24'h2B2B2B);
    expect_word(0, 24'h0A0A0A);
    wait_drain("t2_drain");
    check("t2_wr_count", wr_cyc_q.size(), 6);
    if (wr_cyc_q.size() == 6) begin
      for (int k = 0; k < 3; k++) check("t2_gap_in_burst", wr_cyc_q[k+1] - wr_cyc_q[k], 2);
      check("t2_gap_between", wr_cyc_q[4] - wr_cyc_q[3], 3);
    end

    // Round robin from reset: 0,1,2,0,1,2.
    do_reset();
    for (int rnd = 0; rnd < 2; rnd++)
      for (int r = 0; r < NUM_REQ; r++) begin
        add_word(r, 24'h100000 + 24'(rnd * 16 + r), 1'b1);
        expect_word(r, 24'h100000 + 24'(rnd * 16 + r));
      end
    wait_drain("t3_drain");

    // Backpressure during a burst.
    add_word(0, 24'hC0FFE1, 1'b0);
    add_word(0, 24'hC0FFE2, 1'b1);
    expect_word(0, 24'hC0FFE1);
    expect_word(0, 24'hC0FFE2);
    wait_wr("t4_first_wr");
    bus.wr_buffer_free = 1'b0;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (bus.req_ready != '0 || bus.wr_en || bus.timeout_err) bad++;
    end
    check("t4_quiet", bad, 0);
    bus.wr_buffer_free = 1'b1;
    #1;
    check("t4_ready_on_free", {29'd0, bus.req_ready}, 32'd1);
    step();
    check("t4_wr_after_free", {31'd0, bus.wr_en}, 32'd1);
    check("t4_data_after_free", {8'd0, bus.wr_data}, 32'hC0FFE2);
    wait_drain("t4_drain");

    // Reset after word 2 of 4, req0 regains the bus first.
    for (int w = 1; w <= 4; w++) add_word(0, 24'hD00000 + 24'(w), (w == 4));
    expect_word(0, 24'hD00001);
    expect_word(0, 24'hD00002);
    wait_wr("t5_w1");
    step();
    wait_wr("t5_w2");
    reset_n = 1'b0;
    step();
    check_reset_outputs("t5_rst");
    check("t5_exp_empty", exp_q.size(), 0);
    add_word(1, 24'hE00001, 1'b1);
    expect_word(0, 24'hD00003);
    expect_word(0, 24'hD00004);
    expect_word(1, 24'hE00001);
    step();
    reset_n = 1'b1;
    step();
    check("t5_regrant_valid", {31'd0, bus.grant_valid}, 32'd1);
    check("t5_regrant_idx", {29'd0, bus.grant_idx}, 32'd0);
    wait_drain("t5_drain");

    // Stalled requester: timeout (macro on) or grant held indefinitely (macro off).
    do_reset();
    add_word(0, 24'hF00001, 1'b0);
    add_word(0, 24'hF00002, 1'b0);
    add_word(0, 24'hF00003, 1'b1);
    add_word(1, 24'h1F1F1F, 1'b1);
    expect_word(0, 24'hF00001);
`ifdef SPI_TX_ARB_TIMEOUT_EN
    expect_word(1, 24'h1F1F1F);
    expect_word(0, 24'hF00002);
    expect_word(0, 24'hF00003);
`else
    expect_word(0, 24'hF00002);
    expect_word(0, 24'hF00003);
    expect_word(1, 24'h1F1F1F);
`endif
    wait_wr("t6_w1");
    src_en[0] = 1'b0;
`ifdef SPI_TX_ARB_TIMEOUT_EN
    k_found = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (bus.timeout_err) begin
        k_found = k;
        break;
      end
    end
    check("t6_timeout_delay", k_found, 17);
    check("t6_gvalid_at_tmo", {31'd0, bus.grant_valid}, 32'd0);
    step();
    check("t6_tmo_pulse", {31'd0, bus.timeout_err}, 32'd0);
    check("t6_next_gvalid", {31'd0, bus.grant_valid}, 32'd1);
    check("t6_next_gidx", {29'd0, bus.grant_idx}, 32'd1);
`else
    bad = 0;
    k_found = 0;
    for (int k = 0; k < 120; k++) begin
      step();
      if (bus.timeout_err || bus.wr_en || !bus.grant_valid || bus.grant_idx != 3'd0) bad++;
    end
    check("t6_hold_grant", bad, 0);
`endif
    src_en[0] = 1'b1;
    wait_drain("t6_drain");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_tx_arbiter.md
Name: spi_tx_arbiter

Overview:
- Shares the single spi_slave write path (wr_buffer_free / wr_en / wr_data) among NUM_REQ requesters, e.g. command-reply logic, vector streamer and status reporter.
- Uses round-robin arbitration with burst locking: once a requester is granted, all its words up to and including the word flagged last go out contiguously. This keeps multi-word replies such as 4x24-bit vectors unbroken on MISO.
- Sits between the opcode handlers in top and spi_slave_inst.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- DATA_W, 24, width of one SPI transmit word.
- TIMEOUT_CYCLES, 1024, stall limit used only when SPI_TX_ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- req_valid  in  NUM_REQ  requester i has a word on req_data slice i.
- req_data  in  NUM_REQ*DATA_W  packed words; requester i uses bits [i*DATA_W +: DATA_W].
- req_last  in  NUM_REQ  the current word of requester i ends its burst.
- req_ready  out  NUM_REQ  one-hot, combinational; word of requester i accepted this cycle.
- wr_buffer_free  in  1  from spi_slave; high when a word can be accepted.
- wr_en  out  1  one-cycle write strobe to spi_slave.
- wr_data  out  DATA_W  word to spi_slave.
- grant_valid  out  1  a burst is in progress.
- grant_idx  out  3  index of the granted requester.
- timeout_err  out  1  one-cycle pulse when a burst is aborted.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - Outputs: wr_en=0, wr_data=0, grant_valid=0, grant_idx=0, timeout_err=0, req_ready=0.
  - State returns to IDLE. last_grant = NUM_REQ-1, so requester 0 has first priority.
  - Reset mid-burst abandons the burst. No further req_ready or wr_en is issued for it.
- FSM states: IDLE, BURST, HOLD.
- IDLE:
  - If any req_valid bit is set, select the first set bit scanning from last_grant+1 upward, wrapping modulo NUM_REQ.
  - Register that index into grant_idx, set grant_valid=1, and go to BURST on the next edge.
  - Otherwise stay in IDLE.
- BURST, with g = grant_idx:
  - req_ready[g] = req_valid[g] & wr_buffer_free. All other req_ready bits are 0.
  - On an accept edge: wr_en<=1 for exactly one cycle, wr_data<=req_data slice g, burst_done<=req_last[g], then go to HOLD.
  - With no accept, stay in BURST. Other requesters cannot pre-empt the burst.
- HOLD:
  - Exactly one cycle. It covers the spi_slave latency on wr_buffer_free; wr_buffer_free is ignored in this cycle.
  - If burst_done: go to IDLE, last_grant<=g, grant_valid<=0.
  - Otherwise return to BURST.
- Timing:
  - Latency is req_valid rising in IDLE (cycle n) -> req_ready at n+1 -> wr_en at n+2, with wr_buffer_free high.
  - Peak rate is one word per 2 cycles. wr_en is never asserted on two consecutive cycles.
  - A new grant is decided at the earliest in the cycle after HOLD; back-to-back bursts are separated by one IDLE cycle.
- Simultaneous events:
  - Several requesters valid in IDLE: strict round-robin from last_grant+1.
  - A requester may deassert and reassert req_valid mid-burst; it keeps the grant.
  - wr_data holds its last value when wr_en=0.
- A single-word burst (req_last=1 on the first word) is legal.
- grant_idx is zero-extended and stays valid when NUM_REQ<8.

Optional Feature:
- Macro: SPI_TX_ARB_TIMEOUT_EN.
- Defined:
  - A stall counter clears on entering BURST and on every accept.
  - It increments each BURST cycle in which req_valid[g]=0.
  - When it reaches TIMEOUT_CYCLES: timeout_err pulses for 1 cycle, the FSM goes directly to IDLE, and last_grant<=g. A requester that stalls cannot hold the bus.
  - Cycles with wr_buffer_free=0 do not count toward the stall limit.
- Undefined: no counter. A granted burst waits indefinitely and timeout_err is tied 0.

Test Plan:
- Single word: reset, then req0 valid with data 0xABCDEF, last=1, free=1 -> req_ready[0] one cycle later; wr_en one cycle with wr_data=0xABCDEF; grant_valid drops after HOLD.
- Burst lock: req1 sends a 4-word burst 0x000001..0x000004 (last on the 4th) while req0 and req2 stay valid -> four wr_en pulses, each 2 cycles apart, in order 1,2,3,4 with no interleaving; the next grant goes to req2.
- Round-robin: all three requesters continuously issue single-word bursts -> grant sequence 0,1,2,0,1,2.
- Backpressure: wr_buffer_free=0 for 20 cycles during a burst -> req_ready=0 and wr_en=0 throughout; the word is sent on the first free cycle after that; no timeout.
- Reset mid-burst: reset_n=0 after word 2 of 4 -> all outputs reach their reset values on the next edge; after release, req0 (still valid) is granted first.
- Timeout (macro on, TIMEOUT_CYCLES=16): req0 drops req_valid after word 1 of 3 -> timeout_err pulses after 16 stalled cycles, then FSM goes to IDLE and req1 is granted. With the macro off, the bench confirms the FSM holds the grant for more than 100 cycles.
